// File: rtl/fifo_read_prefetcher.sv
// fifo_read_prefetcher
// Turns the access-enable read port of an upstream FIFO into a registered
// valid/ready stream. Two entries of storage (output register plus one skid
// register) let the upstream keep popping while downstream stalls for one
// cycle, giving full throughput with out_data driven straight from a flop.
module fifo_read_prefetcher #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             flush,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_read_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       level
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic [WIDTH-1:0] skid_reg;
  logic             out_valid_reg;
  logic [1:0]       level_reg;

  logic pop;
  logic take;

  // Pop only when there is room now or room is being made by a transfer this
  // cycle; flush and reset suppress the upstream read entirely.
  assign pop  = resetn && !fifo_empty && !flush && ((state_reg != ST_TWO) || out_ready);
  assign take = out_valid_reg && out_ready;

  assign fifo_read_enable = pop;
  assign out_valid        = out_valid_reg;
  assign out_data         = out_data_reg;
  assign level            = level_reg;

  // Occupancy FSM: moves data between upstream, skid register and output register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_EMPTY;
      out_data_reg  <= '0;
      skid_reg      <= '0;
      out_valid_reg <= 1'b0;
      level_reg     <= 2'd0;
    end else if (flush) begin
      // Stored data is left in place; only occupancy is discarded.
      state_reg     <= ST_EMPTY;
      out_valid_reg <= 1'b0;
      level_reg     <= 2'd0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (pop) begin
            out_data_reg  <= fifo_read_data;
            out_valid_reg <= 1'b1;
            level_reg     <= 2'd1;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (pop && !take) begin
            skid_reg  <= fifo_read_data;
            level_reg <= 2'd2;
            state_reg <= ST_TWO;
          end else if (pop && take) begin
            out_data_reg <= fifo_read_data;
          end else if (take) begin
            out_valid_reg <= 1'b0;
            level_reg     <= 2'd0;
            state_reg     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (take) begin
            out_data_reg <= skid_reg;
            if (pop) begin
              skid_reg <= fifo_read_data;
            end else begin
              level_reg <= 2'd1;
              state_reg <= ST_ONE;
            end
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          out_valid_reg <= 1'b0;
          level_reg     <= 2'd0;
        end
      endcase
    end
  end

endmodule
